// File: rtl/gf2_div_pkg.sv
// Shared types and constants for the GF(2) polynomial divider.
// clmul_ref is a plain shift-xor carry-less product kept for bench-side checking.
package gf2_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int W_DEF = 128;

  function automatic logic [2*W_DEF-1:0] clmul_ref(input logic [W_DEF-1:0] a,
                                                   input logic [W_DEF-1:0] b);
    logic [2*W_DEF-1:0] acc;
    acc = '0;
    for (int k = 0; k < W_DEF; k++) begin
      if (b[k]) acc = acc ^ ({{W_DEF{1'b0}}, a} << k);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf2_msb_index.sv
// Combinational priority encoder: index of the highest set bit, plus an all-zero flag.
// Zero latency; no handshake.
module gf2_msb_index #(
  parameter int W  = 128,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          zero
);

  // Ascending scan so the last hit, i.e. the most significant one, wins.
  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx  = IW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) divider N = Q*D ^ R; latency W+2 (W/2+2 with GF2DIV_RADIX4_EN), 2 when D==0.
// One request in flight; result held in DONE until out_ready, in_ready low while busy.
module gf2_poly_divider
  import gf2_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_quotient,
  output logic [W-1:0] out_remainder,
  output logic         out_dbz
);

  localparam int CW = $clog2(W);

  state_t        state;
  logic [W-1:0]  n_q;
  logic [W-1:0]  d_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  racc;
  logic [CW-1:0] deg_d;
  logic [CW-1:0] cnt;
  logic          dbz_q;

  logic [CW-1:0] msb_idx;
  logic          d_zero;

  gf2_msb_index #(.W(W), .IW(CW)) u_msb (
    .vec  (d_q),
    .idx  (msb_idx),
    .zero (d_zero)
  );

  // Remainder stays below deg(D) between steps, so dropping racc[W-1] never loses a one.
  logic [W-1:0] s1_sh;
  logic [W-1:0] s1;
  logic         s1_hit;

  always_comb begin
    s1_sh  = {racc[W-2:0], n_q[cnt]};
    s1_hit = s1_sh[deg_d];
    s1     = s1_hit ? (s1_sh ^ d_q) : s1_sh;
  end

`ifdef GF2DIV_RADIX4_EN
  logic [CW-1:0] cnt_lo;
  logic [W-1:0]  s2_sh;
  logic [W-1:0]  s2;
  logic          s2_hit;

  always_comb begin
    cnt_lo = cnt - 1'b1;
    s2_sh  = {s1[W-2:0], n_q[cnt_lo]};
    s2_hit = s2_sh[deg_d];
    s2     = s2_hit ? (s2_sh ^ d_q) : s2_sh;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      n_q       <= '0;
      d_q       <= '0;
      q_q       <= '0;
      racc      <= '0;
      deg_d     <= '0;
      cnt       <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            n_q      <= in_dividend;
            d_q      <= in_divisor;
            q_q      <= '0;
            racc     <= '0;
            dbz_q    <= 1'b0;
            in_ready <= 1'b0;
            state    <= PREP;
          end else begin
            in_ready <= 1'b1;
          end
        end

        PREP: begin
          if (d_zero) begin
            racc      <= n_q;
            dbz_q     <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            deg_d <= msb_idx;
            cnt   <= CW'(W - 1);
            state <= DIV;
          end
        end

        DIV: begin
`ifdef GF2DIV_RADIX4_EN
          racc        <= s2;
          q_q[cnt]    <= s1_hit;
          q_q[cnt_lo] <= s2_hit;
          if (cnt == CW'(1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CW'(2);
          end
`else
          racc     <= s1;
          q_q[cnt] <= s1_hit;
          if (cnt == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign out_quotient  = q_q;
  assign out_remainder = racc;
  assign out_dbz       = dbz_q;

endmodule
